// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the zero instruction
// word that stops fetching, and the sequential PC increment.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [63:0] PC_INC    = 64'd4;

    // Instruction addresses must sit on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [63:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/program_counter.sv
// 64-bit program counter: load has priority over increment, otherwise hold.
// The increment wraps modulo 2^64.
module program_counter
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [63:0] load_addr_i,
    input  logic        inc_i,
    output logic [63:0] pc_o
);

    logic [63:0] pc_q;
    logic [63:0] pc_d;

    // Select the next PC: redirect, sequential step, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC register, forced to the boot address while reset is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC to instruction memory, captures the
// returned word into the IF/ID register, and handles stalls, redirects,
// misaligned-redirect faults and halting on an all-zero instruction word.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic        misaligned_fault,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [63:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         if_valid_q, if_valid_d;
    logic         fault_q, fault_d;
    logic [31:0]  count_q, count_d;
    logic         pc_load;
    logic         pc_inc;
    logic [63:0]  pc;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (pc_load),
        .load_addr_i (branch_target),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    // Next-state logic: a redirect beats a stall; once the fault is set the
    // stage stays halted and ignores redirects until reset.
    always_comb begin
        state_d    = state_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        fault_d    = fault_q;
        count_d    = count_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALTED: begin
                if (branch_taken && !fault_q) begin
                    if_valid_d = 1'b0;
                    if (is_word_aligned(branch_target)) begin
                        pc_load = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_HALTED;
                    end
                end else if (state_q == ST_HALTED) begin
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if (HALT_ON_ZERO && (Instruction == ZERO_WORD)) begin
                        if_valid_d = 1'b0;
                        state_d    = ST_HALTED;
                    end else begin
                        if_pc_d    = pc;
                        if_instr_d = Instruction;
                        if_valid_d = 1'b1;
                        count_d    = count_q + 32'd1;
                        pc_inc     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, IF/ID register, fault flag and issue counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            if_pc_q    <= 64'h0;
            if_instr_q <= 32'h0;
            if_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    assign Inst_Address      = pc;
    assign IF_ID_PC          = if_pc_q;
    assign IF_ID_Instruction = if_instr_q;
    assign IF_ID_Valid       = if_valid_q;
    assign misaligned_fault  = fault_q;
    assign halted            = (state_q == ST_HALTED);
    assign fetch_count       = count_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 SHALL have parameter HALT_ON_ZERO, default 1, stop fetching on an all-zero instruction word.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Inst_Address  output  64  current PC, driven to instruction memory.
REQ-006 SHALL have port Instruction  input  32  word returned combinationally by instruction memory for Inst_Address.
REQ-007 SHALL have port stall  input  1  hold PC and IF/ID contents (hazard unit).
REQ-008 SHALL have port branch_taken  input  1  redirect request from EX stage.
REQ-009 SHALL have port branch_target  input  64  redirect address, valid when branch_taken=1.
REQ-010 SHALL have port IF_ID_PC  output  64  PC of captured instruction.
REQ-011 SHALL have port IF_ID_Instruction  output  32  captured instruction word.
REQ-012 SHALL have port IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-013 SHALL have port misaligned_fault  output  1  sticky; redirect target not 4-byte aligned.
REQ-014 SHALL have port halted  output  1  1 while state is HALTED.
REQ-015 SHALL have port fetch_count  output  32  number of instructions issued with IF_ID_Valid=1.

Function
REQ-016 SHALL drive Inst_Address = PC combinationally, no added latency.
REQ-017 SHALL implement states IDLE, RUN, HALTED; IDLE lasts exactly one cycle after reset release, captures nothing, then enters RUN.
REQ-018 SHALL, in RUN with stall=0 and branch_taken=0, on each edge: IF_ID_Instruction<=Instruction, IF_ID_PC<=PC, IF_ID_Valid<=1, PC<=PC+4, fetch_count<=fetch_count+1.
REQ-019 SHALL, with stall=1 and branch_taken=0, hold PC, all IF_ID_* and fetch_count unchanged.
REQ-020 SHALL, on branch_taken=1 with aligned target, set PC<=branch_target and IF_ID_Valid<=0 (flush) in that edge, regardless of stall; branch_taken has priority over stall.
REQ-021 SHALL, on branch_taken=1 in HALTED with aligned target, redirect as REQ-020 and return to RUN.
REQ-022 SHALL, on branch_taken=1 with branch_target[1:0]!=0, leave PC unchanged, set IF_ID_Valid<=0, set misaligned_fault<=1, enter HALTED; fault stays set until reset; further redirects ignored once fault is set.
REQ-023 SHALL, when HALT_ON_ZERO=1 in RUN with stall=0, branch_taken=0 and Instruction==32'h0, set IF_ID_Valid<=0, hold PC, not increment fetch_count, enter HALTED.
REQ-024 SHALL, in HALTED, hold PC and keep IF_ID_Valid=0.
REQ-025 SHALL compute PC+4 modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0); fetch_count wraps modulo 2^32.
REQ-026 SHALL hold IF_ID_PC and IF_ID_Instruction at last values when a bubble is inserted; only IF_ID_Valid marks validity.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force PC=RESET_PC, state=IDLE, IF_ID_PC=0, IF_ID_Instruction=0, IF_ID_Valid=0, misaligned_fault=0, fetch_count=0; halted=0.
REQ-028 SHALL, on reset asserted mid-operation, discard any pending redirect or stall effect; first capture occurs on the second rising edge after reset_n rises.

Structure
REQ-029 SHALL place state encoding (IDLE, RUN, HALTED), the NOP/zero-word constant and the PC increment constant (4) in shared package riscv_pkg.
REQ-030 SHALL contain one sub-module program_counter (64-bit PC register with load, hold, increment, async active-low reset to RESET_PC); IF/ID register and FSM stay in fetch_stage.

Verification
REQ-031 Reset release, memory words 0x00100933, 0x40398633, 0x00C28633 at 0/4/8 -> after IDLE, IF_ID_PC 0,4,8 with those words, IF_ID_Valid=1, fetch_count=3.
REQ-032 stall=1 for 2 cycles at PC=4 -> PC stays 4, IF/ID holds PC 0 word 0x00100933, fetch_count unchanged.
REQ-033 branch_taken=1, target 0x40, stall=1 same cycle -> next cycle PC=0x40, IF_ID_Valid=0; following cycle IF_ID_PC=0x40, IF_ID_Valid=1.
REQ-034 Instruction 0x00000000 at PC=0xC -> IF_ID_Valid=0, halted=1, PC stays 0xC; then branch_taken target 0x0 -> halted=0, fetch resumes at 0.
REQ-035 branch_taken target 0x42 -> misaligned_fault=1, halted=1, PC unchanged; later aligned branch ignored; reset_n=0 clears fault.
REQ-036 reset_n dropped asynchronously mid-cycle during RUN at PC=8 -> outputs immediately at reset values, PC=RESET_PC.
